// File: rtl/ahblite_timer.sv
// ============================================================================
// Module   : ahblite_timer
// Brief    : AHB-Lite zero-wait-state timer with prescaler, reload, one-shot/
//            periodic modes and level IRQ. Define AHBLITE_TIMER_CAPTURE_EN to
//            add the CAPTURE_IN input capture feature.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahblite_timer #(
  parameter int CNT_W = 32,
  parameter int PRE_W = 8
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
`ifdef AHBLITE_TIMER_CAPTURE_EN
  input  logic        CAPTURE_IN,
`endif
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        TIMER_IRQ
);

  localparam logic [2:0] c_A_LOAD   = 3'd0;
  localparam logic [2:0] c_A_VALUE  = 3'd1;
  localparam logic [2:0] c_A_CTRL   = 3'd2;
  localparam logic [2:0] c_A_STATUS = 3'd3;
  localparam logic [2:0] c_A_PRE    = 3'd4;
  localparam logic [2:0] c_A_CAP    = 3'd5;

  logic             r_dp_valid;
  logic [2:0]       r_dp_addr;
  logic             r_dp_write;
  logic             r_dp_word;
  logic [CNT_W-1:0] r_load;
  logic [CNT_W-1:0] r_value;
  logic [PRE_W-1:0] r_prescale;
  logic [PRE_W-1:0] r_pcnt;
  logic             r_en;
  logic             r_ie;
  logic             r_periodic;
  logic             r_pend;

  logic             w_acc;
  logic             w_wr;
  logic             w_wr_load;
  logic             w_wr_ctrl;
  logic             w_wr_status;
  logic             w_wr_pre;
  logic             w_tick;
  logic             w_tev;
  logic             w_zero;
  logic             w_pend_set;
  logic             w_cpend;
  logic [CNT_W-1:0] w_capture;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_acc       = HSEL & HTRANS[1] & HREADY;
  assign w_wr        = r_dp_valid & r_dp_write & r_dp_word;
  assign w_wr_load   = w_wr & (r_dp_addr == c_A_LOAD);
  assign w_wr_ctrl   = w_wr & (r_dp_addr == c_A_CTRL);
  assign w_wr_status = w_wr & (r_dp_addr == c_A_STATUS);
  assign w_wr_pre    = w_wr & (r_dp_addr == c_A_PRE);

  assign w_tick      = r_en & (r_pcnt == r_prescale);
  // A LOAD write in the same cycle pre-empts every effect of the tick.
  assign w_tev       = w_tick & ~w_wr_load;
  assign w_zero      = (r_value == '0);
  assign w_pend_set  = w_tev & w_zero;

  assign w_unused    = ^{HADDR[31:5], HADDR[1:0], HWDATA};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_dp_valid <= 1'b0;
      r_dp_addr  <= '0;
      r_dp_write <= 1'b0;
      r_dp_word  <= 1'b0;
    end else begin
      r_dp_valid <= w_acc;
      if (w_acc) begin
        r_dp_addr  <= HADDR[4:2];
        r_dp_write <= HWRITE;
        r_dp_word  <= (HSIZE == 3'b010);
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_load     <= '0;
      r_prescale <= '0;
    end else begin
      if (w_wr_load) r_load <= HWDATA[CNT_W-1:0];
      if (w_wr_pre)  r_prescale <= HWDATA[PRE_W-1:0];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_pcnt <= '0;
    end else if (w_wr_load || !r_en || w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_value <= '0;
    end else if (w_wr_load) begin
      r_value <= HWDATA[CNT_W-1:0];
    end else if (w_tev) begin
      if (!w_zero)         r_value <= r_value - 1'b1;
      else if (r_periodic) r_value <= r_load;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_en       <= 1'b0;
      r_ie       <= 1'b0;
      r_periodic <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_en       <= HWDATA[0];
      r_ie       <= HWDATA[1];
      r_periodic <= HWDATA[2];
    end else if (w_pend_set && !r_periodic) begin
      r_en <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET)                         r_pend <= 1'b0;
    else if (w_pend_set)                r_pend <= 1'b1;
    else if (w_wr_status && HWDATA[0])  r_pend <= 1'b0;
  end

`ifdef AHBLITE_TIMER_CAPTURE_EN
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  logic             r_cpend;
  logic [CNT_W-1:0] r_capture;
  logic             w_cap_rise;

  assign w_cap_rise = r_sync2 & ~r_sync3;

  // Two flops resynchronise CAPTURE_IN; the third is the edge-detect history.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync3   <= 1'b0;
      r_cpend   <= 1'b0;
      r_capture <= '0;
    end else begin
      r_sync1 <= CAPTURE_IN;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (w_cap_rise) r_capture <= r_value;
      if (w_cap_rise)                    r_cpend <= 1'b1;
      else if (w_wr_status && HWDATA[1]) r_cpend <= 1'b0;
    end
  end

  assign w_cpend   = r_cpend;
  assign w_capture = r_capture;
`else
  assign w_cpend   = 1'b0;
  assign w_capture = '0;
`endif

  always_comb begin
    w_rdata = '0;
    if (r_dp_valid && !r_dp_write) begin
      case (r_dp_addr)
        c_A_LOAD:   w_rdata[CNT_W-1:0] = r_load;
        c_A_VALUE:  w_rdata[CNT_W-1:0] = r_value;
        c_A_CTRL:   w_rdata[2:0]       = {r_periodic, r_ie, r_en};
        c_A_STATUS: w_rdata[1:0]       = {w_cpend, r_pend};
        c_A_PRE:    w_rdata[PRE_W-1:0] = r_prescale;
        c_A_CAP:    w_rdata[CNT_W-1:0] = w_capture;
        default:    w_rdata            = '0;
      endcase
    end
  end

  assign HRDATA    = w_rdata;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign TIMER_IRQ = (r_pend | w_cpend) & r_ie;

endmodule

`default_nettype wire

// File: tb/tb_ahblite_timer.sv
// ============================================================================
// Module   : tb_ahblite_timer
// Brief    : Directed scoreboard bench for ahblite_timer (default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahblite_timer;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        TIMER_IRQ;

  ahblite_timer #(.CNT_W(32), .PRE_W(8)) u_dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP),
    .TIMER_IRQ (TIMER_IRQ)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] data;
    logic        irq;
    logic [7:0]  addr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] nxt_wdata = '0;
  logic        dp_rd = 1'b0;

  // Bus-side view of which cycles carry read data.
  always @(posedge HCLK) begin
    if (HRESET) dp_rd <= 1'b0;
    else        dp_rd <= HSEL & HTRANS[1] & HREADY & ~HWRITE;
  end

  always @(negedge HCLK) begin
    exp_t e;
    checks++;
    if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      errors++;
      $display("FAIL resp: HREADYOUT=%b HRESP=%b required 1/0", HREADYOUT, HRESP);
    end
    if (dp_rd) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: HRDATA=%h with empty scoreboard", HRDATA);
      end else begin
        e = sb.pop_front();
        checks += 2;
        if (HRDATA !== e.data) begin
          errors++;
          $display("FAIL rdata@%h: got %h required %h", e.addr, HRDATA, e.data);
        end
        if (TIMER_IRQ !== e.irq) begin
          errors++;
          $display("FAIL irq@%h: got %b required %b", e.addr, TIMER_IRQ, e.irq);
        end
      end
    end else begin
      checks++;
      if (HRDATA !== 32'h0) begin
        errors++;
        $display("FAIL idle_rdata: got %h required 00000000", HRDATA);
      end
    end
  end

  task automatic cyc(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                     input logic wr, input logic [2:0] size, input logic [31:0] wdata);
    HWDATA    = nxt_wdata;
    HSEL      = sel;
    HTRANS    = trans;
    HADDR     = addr;
    HWRITE    = wr;
    HSIZE     = size;
    nxt_wdata = wdata;
    @(posedge HCLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    cyc(1'b1, 2'b10, addr, 1'b1, 3'b010, data);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] data, input logic irq);
    exp_t e;
    e.data = data;
    e.irq  = irq;
    e.addr = addr[7:0];
    sb.push_back(e);
    cyc(1'b1, 2'b10, addr, 1'b0, 3'b010, 32'h0);
  endtask

  task automatic idle();
    cyc(1'b0, 2'b00, 32'h0, 1'b0, 3'b000, 32'h0);
  endtask

  initial begin
    HRESET = 1'b1;
    HREADY = 1'b1;
    idle();
    idle();
    HRESET = 1'b0;
    for (int a = 0; a <= 'h18; a += 4) rd(a, 32'h0, 1'b0);

    // Write address phase under reset must be dropped
    HRESET = 1'b1;
    wr(32'h00, 32'h55);
    HRESET = 1'b0;
    idle();
    rd(32'h00, 32'h0, 1'b0);

    // One-shot, prescale 0
    wr(32'h00, 32'd5);
    wr(32'h10, 32'd0);
    wr(32'h08, 32'h3);
    rd(32'h04, 32'd5, 1'b0);
    rd(32'h04, 32'd4, 1'b0);
    rd(32'h04, 32'd3, 1'b0);
    rd(32'h04, 32'd2, 1'b0);
    rd(32'h04, 32'd1, 1'b0);
    rd(32'h04, 32'd0, 1'b0);
    rd(32'h04, 32'd0, 1'b1);
    rd(32'h08, 32'h2, 1'b1);
    rd(32'h0C, 32'h1, 1'b1);
    wr(32'h0C, 32'h1);
    rd(32'h0C, 32'h0, 1'b0);

    // Periodic, LOAD=2, prescale 3: tick every 4 cycles, IRQ every 12
    wr(32'h00, 32'd2);
    wr(32'h10, 32'd3);
    wr(32'h08, 32'h7);
    for (int k = 0; k < 13; k++)
      rd(32'h04, (k < 4) ? 32'd2 : (k < 8) ? 32'd1 : (k < 12) ? 32'd0 : 32'd2, (k == 12));
    wr(32'h0C, 32'h1);
    rd(32'h0C, 32'h0, 1'b0);
    for (int k = 0; k < 8; k++) idle();
    wr(32'h0C, 32'h1);
    rd(32'h0C, 32'h1, 1'b1);
    rd(32'h04, 32'd2, 1'b1);

    // Stop, clear, then back-to-back write/read
    wr(32'h08, 32'h0);
    wr(32'h0C, 32'h1);
    wr(32'h00, 32'hA5);
    rd(32'h00, 32'hA5, 1'b0);
    rd(32'h04, 32'hA5, 1'b0);

    // Ignored accesses
    cyc(1'b1, 2'b10, 32'h00, 1'b1, 3'b000, 32'hFF);
    rd(32'h00, 32'hA5, 1'b0);
    cyc(1'b0, 2'b10, 32'h00, 1'b1, 3'b010, 32'h11);
    rd(32'h00, 32'hA5, 1'b0);
    cyc(1'b1, 2'b00, 32'h00, 1'b1, 3'b010, 32'h22);
    rd(32'h00, 32'hA5, 1'b0);
    HREADY = 1'b0;
    cyc(1'b1, 2'b10, 32'h00, 1'b1, 3'b010, 32'h33);
    HREADY = 1'b1;
    rd(32'h04, 32'hA5, 1'b0);
    wr(32'h18, 32'hDEAD_BEEF);
    rd(32'h18, 32'h0, 1'b0);
    rd(32'h14, 32'h0, 1'b0);
    wr(32'h10, 32'h1FF);
    rd(32'h10, 32'hFF, 1'b0);
    wr(32'h00, 32'hFFFF_FFFF);
    rd(32'h00, 32'hFFFF_FFFF, 1'b0);
    rd(32'h0C, 32'h0, 1'b0);

    // LOAD=0 periodic: PEND set every tick, so a clear never sticks
    wr(32'h00, 32'd0);
    wr(32'h10, 32'd0);
    wr(32'h08, 32'hFFFF_FFFF);
    rd(32'h04, 32'd0, 1'b0);
    rd(32'h04, 32'd0, 1'b1);
    wr(32'h0C, 32'h1);
    rd(32'h0C, 32'h1, 1'b1);
    rd(32'h08, 32'h7, 1'b1);
    wr(32'h08, 32'h0);
    idle();
    idle();

    for (int t = 0; t < 20 && sb.size() != 0; t++) idle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected reads outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahblite_timer.md
Name: ahblite_timer

Overview:
- AHB-Lite slave peripheral hanging off one peripheral port of the system interconnect; consumes that port's HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY and returns HREADYOUT/HRDATA/HRESP.
- Provides a prescaled down-counter with reload, one-shot/periodic modes and a level interrupt to the core.
- Always zero-wait-state; HRESP always OKAY.

Parameters:
- CNT_W, 32, counter/LOAD/VALUE width (1..32); read data zero-extended to 32 bits.
- PRE_W, 8, prescaler width; tick rate = HCLK/(PRESCALE+1).

Ports:
- HCLK  in  1  system clock, all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select from the interconnect decoder.
- HADDR  in  32  address; only HADDR[4:2] are decoded.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ.
- HSIZE  in  3  transfer size.
- HWRITE  in  1  1=write.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  bus-wide ready (HREADY_Px from the interconnect).
- HREADYOUT  out  1  constant 1.
- HRDATA  out  32  read data, data phase.
- HRESP  out  1  constant 0.
- TIMER_IRQ  out  1  interrupt = PEND & CTRL.IE.

Behaviour:
- Register map, word offsets: 0x00 LOAD (RW, CNT_W); 0x04 VALUE (RO); 0x08 CTRL (RW: bit0 EN, bit1 IE, bit2 PERIODIC); 0x0C STATUS (read bit0 PEND; write 1 to bit0 clears PEND); 0x10 PRESCALE (RW, PRE_W).
- 0x14 is CAPTURE when the optional feature is compiled in. All other offsets read 0; writes to them are ignored.
- Address phase: access is valid when HSEL & HTRANS[1] & HREADY. On a valid access, register addr[4:2], write flag and word flag (HSIZE==3'b010) into the data-phase registers. Otherwise clear the valid flag.
- Data phase write: on the cycle after a valid write with word flag=1, update the target from HWDATA. Sub-word writes are ignored entirely. Reads of any size return the full word.
- HRDATA: combinational mux on the registered address, valid during the data phase. Drives 0 when no read data phase is active.
- Reset values: LOAD=0, VALUE=0, CTRL=0, PEND=0, PRESCALE=0, prescaler count=0, data-phase valid=0. Outputs after reset: HRDATA=0, TIMER_IRQ=0, HREADYOUT=1, HRESP=0.
- Prescaler: while EN=1, pcnt increments each cycle. When pcnt==PRESCALE, generate tick and set pcnt to 0. While EN=0, pcnt is held at 0.
- On tick, VALUE!=0: VALUE decrements by 1.
- On tick, VALUE==0: set PEND. If PERIODIC=1, VALUE<=LOAD. If PERIODIC=0, EN<=0 and VALUE stays 0.
- A write to LOAD also sets VALUE<=HWDATA[CNT_W-1:0] and pcnt<=0.
- Simultaneous events:
  - LOAD write and tick in the same cycle: the write wins and no decrement happens.
  - STATUS clear and PEND set in the same cycle: the set wins.
  - CTRL write and one-shot EN auto-clear in the same cycle: the CTRL write wins.
- LOAD=0 with PERIODIC=1: interrupt fires on every tick.
- Reset mid-transfer: the pending data-phase write is discarded.
- Latency: a register write is visible to a read in the very next transfer (back-to-back write then read of the same address returns the new value). TIMER_IRQ rises 1 cycle after the terminal tick, because PEND is registered.

Optional Feature:
- Macro: AHBLITE_TIMER_CAPTURE_EN.
- When defined:
  - Adds input CAPTURE_IN (1 bit, asynchronous to the bus), which passes through a 2-flop synchronizer.
  - A rising edge on the synchronized signal copies VALUE into CAPTURE (RO, offset 0x14, reset 0) and sets STATUS bit1 CPEND.
  - Writing 1 to STATUS bit1 clears CPEND; a set in the same cycle wins.
  - TIMER_IRQ = (PEND | CPEND) & IE.
- When undefined: no CAPTURE_IN port, offset 0x14 reads 0, STATUS bit1 reads 0.

Test Plan:
- Reset: assert HRESET 2 cycles -> all registers read 0, TIMER_IRQ=0, HREADYOUT=1, HRESP=0 throughout.
- Write LOAD=5, PRESCALE=0, CTRL=0x3 (one-shot, IE) -> VALUE reads 5,4,..,0. PEND=1 and TIMER_IRQ=1 on the tick after VALUE hits 0, and EN reads 0. Writing STATUS=1 drops TIMER_IRQ the next cycle.
- LOAD=2, PRESCALE=3, CTRL=0x7 -> tick every 4 HCLK, IRQ set every 12 cycles, VALUE reloads to 2. A STATUS clear coinciding with a set leaves PEND=1.
- Back-to-back pipelined transfers (write LOAD=0xA5, read LOAD, read VALUE with HREADY=1) -> reads return 0xA5 and 0xA5.
- Byte write (HSIZE=0) to LOAD=0xFF -> LOAD unchanged. Access with HSEL=0 or HTRANS=IDLE -> no register change. Read of offset 0x18 -> 0.
- With AHBLITE_TIMER_CAPTURE_EN: pulse CAPTURE_IN while VALUE=7 -> CAPTURE reads the value VALUE held 2–3 cycles after the edge, and CPEND=1.
